// File: rtl/tl_inflight_monitor.sv
// Passive TileLink-UL/UH checker for one A/D channel pair: per-source in-flight tracking, burst and
// request/response matching, response watchdog. Define TL_INFLIGHT_ASSERT_EN for simulation error messages.
module tl_inflight_monitor #(
  parameter int SOURCE_BITS = 7,
  parameter int ADDR_BITS   = 30,
  parameter int DATA_BYTES  = 8,
  parameter int SIZE_BITS   = 4,
  parameter int MAX_LGSIZE  = 6,
  parameter int TIMEOUT     = 4096
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_param,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic [DATA_BYTES-1:0]  a_mask,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [1:0]             d_param,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   d_denied,
  input  logic                   d_corrupt,
  output logic                   err_valid,
  output logic [3:0]             err_code,
  output logic [SOURCE_BITS-1:0] err_source,
  output logic                   err_sticky,
  output logic [SOURCE_BITS:0]   inflight_count
);

  localparam int DEPTH  = 1 << SOURCE_BITS;
  localparam int LG_DB  = $clog2(DATA_BYTES);
  localparam int BEAT_W = (MAX_LGSIZE > LG_DB) ? (MAX_LGSIZE - LG_DB) : 1;
  localparam int WD_W   = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] A_PUT_FULL = 3'd0;
  localparam logic [2:0] A_PUT_PART = 3'd1;
  localparam logic [2:0] A_LOGIC    = 3'd3;
  localparam logic [2:0] A_GET      = 3'd4;
  localparam logic [2:0] A_HINT     = 3'd5;
  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK = 3'd2;

  localparam logic [3:0] E_OPCODE  = 4'd1;
  localparam logic [3:0] E_SIZE    = 4'd2;
  localparam logic [3:0] E_BURST   = 4'd3;
  localparam logic [3:0] E_ALIGN   = 4'd4;
  localparam logic [3:0] E_BUSY    = 4'd5;
  localparam logic [3:0] E_UNEXP   = 4'd6;
  localparam logic [3:0] E_MATCH   = 4'd7;
  localparam logic [3:0] E_STATUS  = 4'd8;
  localparam logic [3:0] E_TIMEOUT = 4'd9;

  // Beats-1 of a message; illegal sizes are treated as single-beat so the counter stays in range.
  function automatic logic [BEAT_W-1:0] beats_m1(input logic data_msg, input logic [SIZE_BITS-1:0] sz);
    logic [BEAT_W-1:0] r;
    r = '0;
    if (data_msg && (sz > SIZE_BITS'(LG_DB)) && (sz <= SIZE_BITS'(MAX_LGSIZE))) begin
      for (int i = 0; i < BEAT_W; i++)
        if (i < int'(sz) - LG_DB) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [DATA_BYTES-1:0] lane_mask(input logic [SIZE_BITS-1:0] sz,
                                                      input logic [LG_DB-1:0] offs);
    logic [DATA_BYTES-1:0] r;
    for (int i = 0; i < DATA_BYTES; i++)
      r[i] = ((i >> sz) == (int'(offs) >> sz));
    return r;
  endfunction

  function automatic logic [2:0] resp_opcode(input logic [2:0] op);
    case (op)
      A_PUT_FULL, A_PUT_PART: return D_ACK;
      A_HINT:                 return D_HINT_ACK;
      default:                return D_ACK_DATA;
    endcase
  endfunction

  logic [DEPTH-1:0]     tbl_vld;
  logic [2:0]           tbl_dop  [DEPTH];
  logic [SIZE_BITS-1:0] tbl_size [DEPTH];

  logic [BEAT_W-1:0]      a_cnt, a_bm1_q;
  logic [2:0]             a_op_q, a_param_q;
  logic [SIZE_BITS-1:0]   a_size_q;
  logic [SOURCE_BITS-1:0] a_src_q;
  logic [ADDR_BITS-1:0]   a_addr_q;

  logic [BEAT_W-1:0]      d_cnt, d_bm1_q;
  logic [2:0]             d_op_q;
  logic [SIZE_BITS-1:0]   d_size_q;
  logic [SOURCE_BITS-1:0] d_src_q;

  logic [WD_W-1:0] wd_cnt;

  logic                   a_fire_p0, a_first_p0, a_last_p0, a_accept_p0;
  logic [BEAT_W-1:0]      a_bm1_new_p0;
  logic [ADDR_BITS-1:0]   a_size_mask_p0;
  logic                   a_mask_bad_p0, a_busy_p0, a_diff_p0;
  logic [3:0]             a_code_p0;
  logic                   d_fire_p0, d_first_p0, d_last_p0, d_clear_p0, d_status_bad_p0;
  logic [BEAT_W-1:0]      d_bm1_new_p0;
  logic [SOURCE_BITS-1:0] d_src_eff_p0;
  logic [3:0]             d_code_p0;
  logic                   wd_hit_p0;
  logic [3:0]             err_code_p0;
  logic [SOURCE_BITS-1:0] err_src_p0;

  logic unused_d_param;
  assign unused_d_param = ^d_param;

  // Stage p0: decode both channels against the burst trackers and the in-flight table
  assign a_fire_p0      = a_valid & a_ready;
  assign a_first_p0     = (a_cnt == '0);
  assign a_bm1_new_p0   = beats_m1(a_opcode <= A_LOGIC, a_size);
  assign a_last_p0      = (a_cnt == (a_first_p0 ? a_bm1_new_p0 : a_bm1_q));
  assign a_size_mask_p0 = ~({ADDR_BITS{1'b1}} << a_size);
  assign a_mask_bad_p0  = ((a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PART) || (a_opcode == A_GET)) &&
                          (a_size < SIZE_BITS'(LG_DB)) &&
                          (a_mask != lane_mask(a_size, a_address[LG_DB-1:0]));
  assign a_diff_p0      = (a_opcode != a_op_q) || (a_param != a_param_q) || (a_size != a_size_q) ||
                          (a_source != a_src_q) || (a_address != a_addr_q);

  assign d_fire_p0       = d_valid & d_ready;
  assign d_first_p0      = (d_cnt == '0);
  assign d_bm1_new_p0    = beats_m1(d_opcode == D_ACK_DATA, d_size);
  assign d_last_p0       = (d_cnt == (d_first_p0 ? d_bm1_new_p0 : d_bm1_q));
  assign d_src_eff_p0    = d_first_p0 ? d_source : d_src_q;
  assign d_clear_p0      = d_fire_p0 & d_last_p0 & tbl_vld[d_src_eff_p0];
  assign d_status_bad_p0 = ((d_opcode == D_ACK_DATA) && d_denied && !d_corrupt) ||
                           (((d_opcode == D_ACK) || (d_opcode == D_HINT_ACK)) && d_corrupt);

  // A response retiring this very cycle frees the slot for a new request on the same source.
  assign a_busy_p0 = tbl_vld[a_source] && !(d_clear_p0 && (d_src_eff_p0 == a_source));

  always_comb begin
    a_code_p0 = '0;
    if (a_fire_p0) begin
      if (!a_first_p0) begin
        if (a_diff_p0) a_code_p0 = E_BURST;
      end else if (a_opcode[2:1] == 2'b11)            a_code_p0 = E_OPCODE;
      else if (a_size > SIZE_BITS'(MAX_LGSIZE))       a_code_p0 = E_SIZE;
      else if ((|(a_address & a_size_mask_p0)) || a_mask_bad_p0) a_code_p0 = E_ALIGN;
      else if (a_busy_p0)                             a_code_p0 = E_BUSY;
    end
  end

  assign a_accept_p0 = a_fire_p0 & a_first_p0 & (a_code_p0 == '0);

  always_comb begin
    d_code_p0 = '0;
    if (d_fire_p0) begin
      if (!d_first_p0) begin
        if ((d_source != d_src_q) || (d_opcode != d_op_q) || (d_size != d_size_q)) d_code_p0 = E_BURST;
      end else if (!tbl_vld[d_source]) d_code_p0 = E_UNEXP;
      else if ((d_opcode != tbl_dop[d_source]) || (d_size != tbl_size[d_source])) d_code_p0 = E_MATCH;
      else if (d_status_bad_p0) d_code_p0 = E_STATUS;
    end
  end

  assign wd_hit_p0 = (inflight_count != '0) && !d_fire_p0 && (wd_cnt == WD_MAX - WD_W'(1));

  // Lowest code wins; an A/D tie on the burst code is attributed to the A source.
  always_comb begin
    err_code_p0 = a_code_p0;
    err_src_p0  = a_source;
    if ((d_code_p0 != '0) && ((err_code_p0 == '0) || (d_code_p0 < err_code_p0))) begin
      err_code_p0 = d_code_p0;
      err_src_p0  = d_source;
    end
    if (wd_hit_p0 && (err_code_p0 == '0)) err_code_p0 = E_TIMEOUT;
    if ((err_code_p0 == '0) || (err_code_p0 == E_TIMEOUT)) err_src_p0 = '0;
  end

  // Stage p1: state update and registered error report
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_cnt <= '0;
      d_cnt <= '0;
    end else begin
      if (a_fire_p0) a_cnt <= a_last_p0 ? '0 : a_cnt + BEAT_W'(1);
      if (d_fire_p0) d_cnt <= d_last_p0 ? '0 : d_cnt + BEAT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (a_fire_p0 && a_first_p0) begin
      a_op_q    <= a_opcode;
      a_param_q <= a_param;
      a_size_q  <= a_size;
      a_src_q   <= a_source;
      a_addr_q  <= a_address;
      a_bm1_q   <= a_bm1_new_p0;
    end
    if (d_fire_p0 && d_first_p0) begin
      d_op_q   <= d_opcode;
      d_size_q <= d_size;
      d_src_q  <= d_source;
      d_bm1_q  <= d_bm1_new_p0;
    end
    if (a_accept_p0) begin
      tbl_dop[a_source]  <= resp_opcode(a_opcode);
      tbl_size[a_source] <= a_size;
    end
  end

  // Clear before set so a same-cycle retire and re-issue leaves the entry valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tbl_vld <= '0;
    end else begin
      if (d_clear_p0)  tbl_vld[d_src_eff_p0] <= 1'b0;
      if (a_accept_p0) tbl_vld[a_source]     <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_count <= '0;
    end else begin
      case ({a_accept_p0, d_clear_p0})
        2'b10:   inflight_count <= inflight_count + {{SOURCE_BITS{1'b0}}, 1'b1};
        2'b01:   inflight_count <= inflight_count - {{SOURCE_BITS{1'b0}}, 1'b1};
        default: inflight_count <= inflight_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (d_fire_p0 || (inflight_count == '0)) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_source <= '0;
      err_sticky <= 1'b0;
    end else begin
      err_valid  <= (err_code_p0 != '0);
      err_code   <= err_code_p0;
      err_source <= err_src_p0;
      if (err_code_p0 != '0) err_sticky <= 1'b1;
    end
  end

`ifdef TL_INFLIGHT_ASSERT_EN
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (!err_valid)
        else $error("tl_inflight_monitor: err_code %0d err_source 0x%0h at %0t", err_code, err_source, $time);
    end
  end
`else
  // Default build: error reporting through the ports only.
`endif

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Directed bench for tl_inflight_monitor: transaction-level model compared every cycle plus literal checks.
`timescale 1ns/1ps
module tb_tl_inflight_monitor;
  localparam int SB = 7, AB = 30, DB = 8, ZB = 4, MAXLG = 6, TO = 4096;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          a_valid = 1'b0, a_ready = 1'b1;
  logic [2:0]    a_opcode = '0, a_param = '0;
  logic [ZB-1:0] a_size = '0;
  logic [SB-1:0] a_source = '0;
  logic [AB-1:0] a_address = '0;
  logic [DB-1:0] a_mask = '0;
  logic          d_valid = 1'b0, d_ready = 1'b1;
  logic [2:0]    d_opcode = '0;
  logic [1:0]    d_param = '0;
  logic [ZB-1:0] d_size = '0;
  logic [SB-1:0] d_source = '0;
  logic          d_denied = 1'b0, d_corrupt = 1'b0;
  logic          err_valid, err_sticky;
  logic [3:0]    err_code;
  logic [SB-1:0] err_source;
  logic [SB:0]   inflight_count;

  tl_inflight_monitor #(.SOURCE_BITS(SB), .ADDR_BITS(AB), .DATA_BYTES(DB), .SIZE_BITS(ZB),
                        .MAX_LGSIZE(MAXLG), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .err_valid(err_valid), .err_code(err_code), .err_source(err_source), .err_sticky(err_sticky),
    .inflight_count(inflight_count));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: outstanding table by source, beats remaining per channel, idle counter.
  bit  m_vld [1<<SB];
  int  m_op  [1<<SB];
  int  m_sz  [1<<SB];
  int  m_n, m_a_left, m_d_left, m_idle;
  int  m_a_op, m_a_param, m_a_sz, m_a_src, m_d_op, m_d_sz, m_d_src;
  longint m_a_addr;
  bit  m_err_v, m_sticky;
  int  m_code, m_src;

  function automatic int n_beats(input bit data_msg, input int sz);
    if (!data_msg || sz > MAXLG || (1 << sz) <= DB) return 1;
    return (1 << sz) / DB;
  endfunction

  function automatic int resp_op(input int aop);
    if (aop <= 1) return 0;
    if (aop == 5) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < (1 << SB); i++) m_vld[i] = 1'b0;
    m_n = 0; m_a_left = 0; m_d_left = 0; m_idle = 0;
    m_err_v = 1'b0; m_sticky = 1'b0; m_code = 0; m_src = 0;
  endtask

  task automatic model_step();
    int aop, asz, asrc, apar, am, dop, dsz, dsrc, acode, dcode, code, src, n_pre, bytes, exp_mask;
    longint aadr;
    bit af, df, hit, wrong_mask;
    aop = int'(a_opcode); asz = int'(a_size); asrc = int'(a_source); apar = int'(a_param);
    am = int'(a_mask); aadr = longint'(a_address);
    dop = int'(d_opcode); dsz = int'(d_size); dsrc = int'(d_source);
    af = a_valid && a_ready;
    df = d_valid && d_ready;
    acode = 0; dcode = 0; hit = 1'b0; n_pre = m_n;
    if (df) begin
      if (m_d_left == 0) begin
        m_d_op = dop; m_d_sz = dsz; m_d_src = dsrc;
        m_d_left = n_beats(dop == 1, dsz);
        if (!m_vld[dsrc]) dcode = 6;
        else if (m_op[dsrc] != dop || m_sz[dsrc] != dsz) dcode = 7;
        else if ((dop == 1 && d_denied && !d_corrupt) || (dop != 1 && d_corrupt)) dcode = 8;
      end else if (dop != m_d_op || dsz != m_d_sz || dsrc != m_d_src) dcode = 3;
      m_d_left--;
      if (m_d_left == 0 && m_vld[m_d_src]) begin
        m_vld[m_d_src] = 1'b0;
        m_n--;
      end
    end
    if (af) begin
      if (m_a_left == 0) begin
        m_a_op = aop; m_a_param = apar; m_a_sz = asz; m_a_src = asrc; m_a_addr = aadr;
        m_a_left = n_beats(aop <= 3, asz);
        bytes = 1 << asz;
        exp_mask = ((1 << bytes) - 1) << (int'(aadr % DB) / bytes * bytes);
        wrong_mask = (aop == 0 || aop == 1 || aop == 4) && bytes < DB && am != exp_mask;
        if (aop >= 6) acode = 1;
        else if (asz > MAXLG) acode = 2;
        else if ((aadr % bytes) != 0 || wrong_mask) acode = 4;
        else if (m_vld[asrc]) acode = 5;
        else begin
          m_vld[asrc] = 1'b1; m_op[asrc] = resp_op(aop); m_sz[asrc] = asz; m_n++;
        end
      end else if (aop != m_a_op || apar != m_a_param || asz != m_a_sz || asrc != m_a_src ||
                   aadr != m_a_addr) acode = 3;
      m_a_left--;
    end
    if (df || n_pre == 0) m_idle = 0;
    else if (m_idle < TO - 1) begin
      m_idle++;
      if (m_idle == TO - 1) hit = 1'b1;
    end
    code = 0; src = 0;
    if (acode != 0) begin code = acode; src = asrc; end
    if (dcode != 0 && (code == 0 || dcode < code)) begin code = dcode; src = dsrc; end
    if (hit && code == 0) begin code = 9; src = 0; end
    m_err_v = (code != 0); m_code = code; m_src = src;
    if (code != 0) m_sticky = 1'b1;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    check("cycle_model", 64'({err_valid, err_code, err_source, err_sticky, inflight_count}),
          64'({m_err_v, 4'(m_code), 7'(m_src), m_sticky, 8'(m_n)}));
  end

  task automatic set_a(input int op, input int sz, input int src, input longint addr, input int mask);
    a_valid = 1'b1; a_opcode = 3'(op); a_param = '0; a_size = ZB'(sz);
    a_source = SB'(src); a_address = AB'(addr); a_mask = DB'(mask);
  endtask

  task automatic set_d(input int op, input int sz, input int src, input bit den, input bit cor);
    d_valid = 1'b1; d_opcode = 3'(op); d_size = ZB'(sz); d_source = SB'(src);
    d_denied = den; d_corrupt = cor;
  endtask

  task automatic a_req(input int op, input int sz, input int src, input longint addr, input int mask);
    set_a(op, sz, src, addr, mask);
    @(negedge clock);
    a_valid = 1'b0;
  endtask

  task automatic d_beat(input int op, input int sz, input int src, input bit den, input bit cor);
    set_d(op, sz, src, den, cor);
    @(negedge clock);
    d_valid = 1'b0;
  endtask

  task automatic expect_err(input string name, input int code, input int src);
    check({name, "_valid"}, 64'(err_valid), 64'd1);
    check({name, "_code"}, 64'(err_code), 64'(code));
    check({name, "_source"}, 64'(err_source), 64'(src));
  endtask

  initial begin
    int pulses, hit_at, hit_code;
    #1 reset_n = 1'b0;
    #1 check("reset_outputs", 64'({err_valid, err_code, err_source, err_sticky, inflight_count}), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // 64-byte Get answered by an 8-beat AccessAckData
    a_req(4, 6, 'h12, 'h40, 'hFF);
    check("get64_inflight", 64'(inflight_count), 64'd1);
    check("get64_noerr", 64'(err_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      d_beat(1, 6, 'h12, 1'b0, 1'b0);
      if (i == 6) check("ackdata_beat7_inflight", 64'(inflight_count), 64'd1);
    end
    check("ackdata_done_inflight", 64'(inflight_count), 64'd0);
    check("ackdata_noerr", 64'(err_sticky), 64'd0);

    // Reissue on a busy source
    a_req(0, 3, 5, 'h100, 'hFF);
    a_req(0, 3, 5, 'h100, 'hFF);
    expect_err("busy", 5, 5);
    check("busy_sticky", 64'(err_sticky), 64'd1);
    check("busy_inflight", 64'(inflight_count), 64'd1);
    d_beat(0, 3, 5, 1'b0, 1'b0);
    check("busy_drain", 64'(inflight_count), 64'd0);

    d_beat(0, 3, 9, 1'b0, 1'b0);
    expect_err("unexpected", 6, 9);

    a_req(4, 2, 'h0A, 'h6, 'hF0);
    expect_err("misalign", 4, 'h0A);
    a_req(4, 7, 'h0B, 'h0, 'hFF);
    expect_err("oversize", 2, 'h0B);

    a_req(4, 1, 7, 'h2, 'h0C);
    check("mask_ok", 64'(err_valid), 64'd0);
    a_req(4, 1, 8, 'h2, 'h03);
    expect_err("mask_bad", 4, 8);
    d_beat(1, 1, 7, 1'b0, 1'b0);
    check("mask_drain", 64'(inflight_count), 64'd0);

    a_req(7, 0, 3, 'h0, 'h01);
    expect_err("bad_opcode", 1, 3);
    a_ready = 1'b0;
    a_req(7, 0, 3, 'h0, 'h01);
    a_ready = 1'b1;
    check("no_fire_noerr", 64'(err_valid), 64'd0);

    a_req(4, 3, 6, 'h8, 'hFF);
    d_beat(0, 3, 6, 1'b0, 1'b0);
    expect_err("resp_mismatch", 7, 6);
    check("mismatch_clears", 64'(inflight_count), 64'd0);
    a_req(4, 3, 4, 'h8, 'hFF);
    d_beat(1, 3, 4, 1'b1, 1'b0);
    expect_err("denied_status", 8, 4);

    // 4-beat PutFull with a wrong address on beat 2
    for (int i = 0; i < 4; i++) begin
      set_a(0, 5, 2, (i == 1) ? 'h28 : 'h20, 'hFF);
      @(negedge clock);
      if (i == 0) check("put_beat1_inflight", 64'(inflight_count), 64'd1);
      if (i == 1) expect_err("burst_change", 3, 2);
    end
    a_valid = 1'b0;
    check("put_tail_noerr", 64'(err_valid), 64'd0);
    d_beat(0, 5, 2, 1'b0, 1'b0);

    // Same-cycle retire and reissue on source 3
    a_req(4, 3, 3, 'h18, 'hFF);
    set_a(4, 3, 3, 'h18, 'hFF);
    set_d(1, 3, 3, 1'b0, 1'b0);
    @(negedge clock);
    a_valid = 1'b0; d_valid = 1'b0;
    check("reissue_noerr", 64'(err_valid), 64'd0);
    check("reissue_inflight", 64'(inflight_count), 64'd1);
    d_beat(1, 3, 3, 1'b0, 1'b0);
    check("reissue_drain", 64'(inflight_count), 64'd0);

    // Watchdog: expect exactly one timeout pulse
    a_req(4, 3, 1, 'h8, 'hFF);
    pulses = 0; hit_at = 0; hit_code = 0;
    for (int i = 2; i <= 4100; i++) begin
      @(negedge clock);
      if (err_valid) begin pulses++; hit_at = i; hit_code = int'(err_code); end
    end
    check("timeout_pulses", 64'(pulses), 64'd1);
    check("timeout_cycle", 64'(hit_at), 64'd4096);
    check("timeout_code", 64'(hit_code), 64'd9);
    d_beat(1, 3, 1, 1'b0, 1'b0);
    check("timeout_clear_noerr", 64'(err_valid), 64'd0);
    repeat (3) @(negedge clock);
    check("timeout_no_repeat", 64'(err_valid), 64'd0);

    // Async reset in the middle of a response burst
    a_req(4, 6, 'h20, 'h0, 'hFF);
    for (int i = 0; i < 3; i++) d_beat(1, 6, 'h20, 1'b0, 1'b0);
    set_d(1, 6, 'h20, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("midburst_reset", 64'({err_valid, err_code, err_source, err_sticky, inflight_count}), 64'd0);
    d_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    d_beat(1, 6, 'h20, 1'b0, 1'b0);
    expect_err("post_reset_first_beat", 6, 'h20);
    check("post_reset_inflight", 64'(inflight_count), 64'd0);

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
